// File: rtl/alu_8bit.sv
// Registered integer ALU used as the execute stage behind the instruction decoder.
// Accepts an op on each cycle in_valid is high and registers the result and flags.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_overflow;
  logic             sign_a;
  logic             sign_b;

  // One extra bit on each operand exposes carry-out and borrow as the MSB.
  assign sum    = {1'b0, operandA} + {1'b0, operandB};
  assign diff   = {1'b0, operandA} - {1'b0, operandB};
  assign sign_a = operandA[WIDTH-1];
  assign sign_b = operandB[WIDTH-1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
    next_result   = '0;
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    case (opcode)
      OP_ADD: begin
        next_result   = sum[WIDTH-1:0];
        next_carry    = sum[WIDTH];
        next_overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      OP_SUB: begin
        next_result   = diff[WIDTH-1:0];
        next_carry    = diff[WIDTH];
        next_overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      OP_AND: next_result = operandA & operandB;
      OP_OR:  next_result = operandA | operandB;
      OP_XOR: next_result = operandA ^ operandB;
      OP_NOT: next_result = ~operandA;
      OP_SHL: begin
        next_result = {operandA[WIDTH-2:0], 1'b0};
        next_carry  = operandA[WIDTH-1];
      end
      OP_SHR: begin
        next_result = {1'b0, operandA[WIDTH-1:1]};
        next_carry  = operandA[0];
      end
      default: next_result = '0;
    endcase
  end

  // Result and flags only load on an accepted op, so idle-cycle X inputs never reach them.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= next_result;
        carry    <= next_carry;
        zero     <= (next_result == '0);
        negative <= next_result[WIDTH-1];
        overflow <= next_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: hand-computed results and flags per opcode,
// handshake gap behaviour and asynchronous reset mid-stream.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] result;
  logic       out_valid;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] last_r;
  logic [3:0] last_f;

  alu_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .opcode   (opcode),
    .operandA (operand_a),
    .operandB (operand_b),
    .result   (result),
    .out_valid(out_valid),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flag vector order everywhere: {out_valid, carry, zero, negative, overflow}.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_czn_v);
    @(negedge clk);
    in_valid  = 1'b1;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    check({tag, "_res"}, {24'd0, result}, {24'd0, exp_r});
    check({tag, "_flg"}, {27'd0, out_valid, carry, zero, negative, overflow},
          {27'd0, 1'b1, exp_czn_v});
    last_r = exp_r;
    last_f = exp_czn_v;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = 3'b000;
    operand_a = 8'd0;
    operand_b = 8'd0;
    #12;
    check("reset_res", {24'd0, result}, 32'd0);
    check("reset_flg", {27'd0, out_valid, carry, zero, negative, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //     tag         op      A      B      R      CZNV
    do_op("add_small", 3'b000, 8'd10,  8'd5,   8'd15,  4'b0000);
    do_op("add_carry", 3'b000, 8'd200, 8'd100, 8'd44,  4'b1000);
    do_op("add_ovf",   3'b000, 8'd127, 8'd1,   8'd128, 4'b0011);
    do_op("sub_pos",   3'b001, 8'd20,  8'd7,   8'd13,  4'b0000);
    do_op("sub_zero",  3'b001, 8'd5,   8'd5,   8'd0,   4'b0100);
    do_op("sub_borr",  3'b001, 8'd3,   8'd5,   8'd254, 4'b1010);
    do_op("sub_ovf",   3'b001, 8'h80,  8'h01,  8'h7F,  4'b0001);
    do_op("and",       3'b010, 8'hAA,  8'hCC,  8'h88,  4'b0010);
    do_op("or",        3'b011, 8'hAA,  8'h55,  8'hFF,  4'b0010);
    do_op("xor",       3'b100, 8'hF0,  8'h0F,  8'hFF,  4'b0010);
    do_op("not",       3'b101, 8'hF0,  8'h33,  8'h0F,  4'b0000);
    do_op("shl",       3'b110, 8'h0F,  8'hFF,  8'h1E,  4'b0000);
    do_op("shr",       3'b111, 8'hF0,  8'hFF,  8'h78,  4'b0000);
    do_op("shl_out",   3'b110, 8'h80,  8'h00,  8'h00,  4'b1100);
    do_op("shr_out",   3'b111, 8'h01,  8'h00,  8'h00,  4'b1100);
    do_op("add_wrap",  3'b000, 8'hFF,  8'h01,  8'h00,  4'b1100);

    // Idle cycle with X inputs: out_valid drops, result and flags hold.
    @(negedge clk);
    in_valid  = 1'b0;
    opcode    = 3'bxxx;
    operand_a = 8'hxx;
    operand_b = 8'hxx;
    @(posedge clk);
    #1;
    check("gap_res", {24'd0, result}, {24'd0, last_r});
    check("gap_flg", {27'd0, out_valid, carry, zero, negative, overflow}, {27'd0, 1'b0, last_f});

    do_op("after_gap", 3'b111, 8'h81, 8'h00, 8'h40, 4'b1000);

    // Asynchronous reset between edges while an op is pending.
    @(negedge clk);
    in_valid  = 1'b1;
    opcode    = 3'b000;
    operand_a = 8'd200;
    operand_b = 8'd100;
    #2;
    rst = 1'b1;
    #1;
    check("arst_res", {24'd0, result}, 32'd0);
    check("arst_flg", {27'd0, out_valid, carry, zero, negative, overflow}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold", {19'd0, result, out_valid, carry, zero, negative, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 3'b001, 8'd3, 8'd5, 8'd254, 4'b1010);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("end_idle", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
